// File: rtl/axi_rb_slave_ram.sv
// AXI4 read-only slave memory: one AR at a time, ARLEN+1 beats on R with RLAST.
// A side load port preloads the word array; contents survive reset.
module axi_rb_slave_ram #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [1:0]        s_axi_arburst,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic              r_fixed;
  logic [1:0]        r_es;
  logic [3:0]        r_wait;
  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_ar_hs;
  logic              w_r_hs;
  logic [ADDR_W-1:0] w_stride;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_last;
  logic              w_unused;

  assign w_ar_hs     = s_axi_arvalid && r_arready;
  assign w_r_hs      = r_rvalid && s_axi_rready;
  assign w_stride    = ADDR_W'(3'd1 << r_es);
  assign w_next_addr = r_fixed ? r_addr : r_addr + w_stride;

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign busy          = (r_state != S_IDLE);

  // Byte-offset and above-depth address bits never select a word.
  assign w_unused = ^{ld_addr[1:0], ld_addr[ADDR_W-1:IDX_W+2],
                      w_rd_addr[1:0], w_rd_addr[ADDR_W-1:IDX_W+2]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state plus the single memory read port: every beat's word is fetched
  // on the edge that makes it visible, so rdata holds steady during stalls.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_addr;
    w_rd_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ar_hs) begin
          if (RD_LATENCY > 0) begin
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_BEAT;
            w_rd_en      = 1'b1;
            w_rd_addr    = s_axi_araddr;
            w_rd_last    = (s_axi_arlen == 8'd0);
          end
        end
      end
      S_WAIT: begin
        if (r_wait == 4'd0) begin
          w_state_next = S_BEAT;
          w_rd_en      = 1'b1;
          w_rd_addr    = r_addr;
          w_rd_last    = (r_len == 8'd0);
        end
      end
      S_BEAT: begin
        if (w_r_hs) begin
          if (r_beat == r_len) begin
            w_state_next = S_IDLE;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_next_addr;
            w_rd_last = (8'(r_beat + 8'd1) == r_len);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr[IDX_W+1:2]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_len     <= 8'd0;
      r_beat    <= 8'd0;
      r_fixed   <= 1'b0;
      r_es      <= 2'd0;
      r_wait    <= 4'd0;
    end else begin
      r_arready <= (w_state_next == S_IDLE);
      r_rvalid  <= (w_state_next == S_BEAT);
      if (w_ar_hs) begin
        r_addr  <= s_axi_araddr;
        r_len   <= s_axi_arlen;
        r_beat  <= 8'd0;
        r_fixed <= (s_axi_arburst == 2'b00);
        r_es    <= (s_axi_arsize > 3'd2) ? 2'd2 : s_axi_arsize[1:0];
        r_rresp <= (s_axi_arsize > 3'd2) ? 2'b10 : 2'b00;
        r_wait  <= 4'(RD_LATENCY - 1);
      end
      if (r_state == S_WAIT) r_wait <= r_wait - 4'd1;
      if (r_state == S_BEAT && w_r_hs) begin
        r_beat <= 8'(r_beat + 8'd1);
        r_addr <= w_next_addr;
        if (r_beat == r_len) r_rlast <= 1'b0;
      end
      if (w_rd_en) begin
        r_rdata <= r_mem[w_rd_addr[IDX_W+1:2]];
        r_rlast <= w_rd_last;
      end
    end
  end

endmodule

// File: tb/tb_axi_rb_slave_ram.sv
// Directed bench for axi_rb_slave_ram: one zero-latency instance and one with RD_LATENCY=3.
// Inputs are driven and outputs sampled on the falling edge.
module tb_axi_rb_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arvalid_l;
  logic        rready;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;

  logic        arready, rvalid, rlast, busy;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        arready_l, rvalid_l, rlast_l, busy_l;
  logic [31:0] rdata_l;
  logic [1:0]  rresp_l;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_resp;

  always #5 clk = ~clk;

  axi_rb_slave_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .RD_LATENCY(0)) u_dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(araddr), .s_axi_arburst(arburst), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  axi_rb_slave_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .RD_LATENCY(3)) u_dut_lat (
    .clk(clk), .rst(rst),
    .s_axi_araddr(araddr), .s_axi_arburst(arburst), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arvalid(arvalid_l), .s_axi_arready(arready_l),
    .s_axi_rdata(rdata_l), .s_axi_rresp(rresp_l), .s_axi_rlast(rlast_l),
    .s_axi_rvalid(rvalid_l), .s_axi_rready(rready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issue one AR to the zero-latency instance; arready must already be high.
  task automatic send_ar(input logic [15:0] a, input logic [7:0] len,
                         input logic [1:0] bt, input logic [2:0] sz, input string tag);
    chk({tag, "_arready_pre"}, 32'(arready), 32'd1);
    araddr = a; arlen = len; arburst = bt; arsize = sz; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk({tag, "_arready_drop"}, 32'(arready), 32'd0);
  endtask

  // Drain a burst against exp_q with rready following pat (bit per cycle, then 1).
  task automatic collect(input logic [15:0] pat, input string tag);
    int nexp = exp_q.size();
    int got = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    while (got < nexp && cyc < 64) begin
      rready = (cyc < 16) ? pat[cyc] : 1'b1;
      if (stall) begin
        chk({tag, "_hold_v"}, 32'(rvalid), 32'd1);
        chk({tag, "_hold_d"}, rdata, pd);
        chk({tag, "_hold_l"}, 32'(rlast), 32'(pl));
      end
      if (rvalid && rready) begin
        chk({tag, "_data"}, rdata, exp_q[got]);
        chk({tag, "_last"}, 32'(rlast), 32'(got == nexp - 1));
        chk({tag, "_resp"}, 32'(rresp), 32'(exp_resp));
        got++;
      end
      stall = rvalid && !rready;
      pd = rdata;
      pl = rlast;
      step();
      cyc++;
    end
    rready = 1'b1;
    chk({tag, "_beats"}, 32'(got), 32'(nexp));
    chk({tag, "_rvalid_end"}, 32'(rvalid), 32'd0);
    chk({tag, "_arready_end"}, 32'(arready), 32'd1);
    $display("burst %s: beats=%0d cycles=%0d", tag, got, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; araddr = '0; arburst = 2'd1; arlen = '0; arsize = 3'd2;
    arvalid = 1'b0; arvalid_l = 1'b0; rready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    step();
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Preload while reset is held: the load port is live in every state.
    ld_en = 1'b1;
    for (int w = 0; w < 256; w++) begin
      ld_addr = 16'(w * 4);
      ld_data = 32'h1000 + 32'(w);
      step();
    end
    ld_en = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_arready_lat", 32'(arready_l), 32'd1);

    // 1: INCR burst, back-to-back beats.
    send_ar(16'h0010, 8'd3, 2'd1, 3'd2, "t1");
    chk("t1_first_rvalid", 32'(rvalid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rvalid", 32'(rvalid), 32'd1);
      chk("t1_data", rdata, 32'h1004 + 32'(i));
      chk("t1_last", 32'(rlast), 32'(i == 3));
      chk("t1_resp", 32'(rresp), 32'd0);
      step();
    end
    chk("t1_rvalid_end", 32'(rvalid), 32'd0);
    chk("t1_arready_end", 32'(arready), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    $display("burst t1: beats=4");

    // 2: same burst with rready 1,0,0,1,0,1,1.
    send_ar(16'h0010, 8'd3, 2'd1, 3'd2, "t2");
    exp_q = {32'h1004, 32'h1005, 32'h1006, 32'h1007};
    exp_resp = 2'd0;
    collect(16'hFFE9, "t2");

    // 3: FIXED burst.
    send_ar(16'h0020, 8'd2, 2'd0, 3'd2, "t3");
    exp_q = {32'h1008, 32'h1008, 32'h1008};
    exp_resp = 2'd0;
    collect(16'hFFFF, "t3");

    // 4: wrap at the top of the address space, then oversize arsize.
    send_ar(16'hFFFC, 8'd1, 2'd1, 3'd2, "t4a");
    exp_q = {32'h10FF, 32'h1000};
    exp_resp = 2'd0;
    collect(16'hFFFF, "t4a");
    send_ar(16'hFFFC, 8'd1, 2'd1, 3'd5, "t4b");
    exp_q = {32'h10FF, 32'h1000};
    exp_resp = 2'd2;
    collect(16'hFFFF, "t4b");

    // 5: RD_LATENCY=3 instance, single beat.
    araddr = 16'h0000; arlen = 8'd0; arburst = 2'd1; arsize = 3'd2;
    arvalid_l = 1'b1;
    step();
    arvalid_l = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("t5_rvalid_wait", 32'(rvalid_l), 32'd0);
      chk("t5_busy_wait", 32'(busy_l), 32'd1);
      step();
    end
    chk("t5_rvalid", 32'(rvalid_l), 32'd1);
    chk("t5_data", rdata_l, 32'h1000);
    chk("t5_last", 32'(rlast_l), 32'd1);
    step();
    chk("t5_rvalid_end", 32'(rvalid_l), 32'd0);
    $display("burst t5: latency=4 beats=1");

    // 6: reset mid-burst, then memory is still intact.
    send_ar(16'h0000, 8'd7, 2'd1, 3'd2, "t6");
    chk("t6_beat0", rdata, 32'h1000);
    step();
    chk("t6_beat1", rdata, 32'h1001);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rvalid_after_rst", 32'(rvalid), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    step();
    chk("t6_arready_after_rst", 32'(arready), 32'd1);
    chk("t6_rvalid_idle", 32'(rvalid), 32'd0);
    send_ar(16'h0000, 8'd0, 2'd1, 3'd2, "t6n");
    exp_q = {32'h1000};
    exp_resp = 2'd0;
    collect(16'hFFFF, "t6n");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
